// File: rtl/mem_pkg.sv
// Shared defaults, FSM encoding and port identifiers for the arbitrated single-port RAM.
package mem_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 6;
  localparam int unsigned DEF_INIT_VALUE = 0;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM with a registered, reset-cleared read output (read-first).
module single_port_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-port round-robin front end for a single-port RAM; clears the array after reset, then
// shares the port between requesters A and B with tagged one-cycle read returns.
module sp_ram_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(DEF_INIT_VALUE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  init_done
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  last_q, last_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_tag_q, rd_tag_d;
  logic                  run;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Outputs are masked while rst is high so a mid-operation reset takes effect immediately.
  assign run       = (state_q == StRun) && !rst;
  assign init_done = run;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (run) begin
      if (req_a && req_b) begin
        if (last_q == PORT_B) begin
          gnt_a = 1'b1;
        end else begin
          gnt_b = 1'b1;
        end
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    last_d     = last_q;
    rd_valid_d = (gnt_a && !we_a) || (gnt_b && !we_b);
    rd_tag_d   = gnt_b ? PORT_B : PORT_A;
    unique case (state_q)
      StInit: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (gnt_a) begin
          last_d = PORT_A;
        end else if (gnt_b) begin
          last_d = PORT_B;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      clr_addr_q <= '0;
      last_q     <= PORT_B;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= PORT_A;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      last_q     <= last_d;
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = clr_addr_q;
    ram_din  = INIT_VALUE;
    if (state_q == StInit) begin
      ram_we = !rst;
    end else if (gnt_a) begin
      ram_we   = we_a;
      ram_addr = addr_a;
      ram_din  = wdata_a;
    end else if (gnt_b) begin
      ram_we   = we_b;
      ram_addr = addr_b;
      ram_din  = wdata_b;
    end
  end

  single_port_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk (clk),
    .rst (rst),
    .we  (ram_we),
    .addr(ram_addr),
    .din (ram_din),
    .dout(ram_dout)
  );

  assign rvalid_a = rd_valid_q && (rd_tag_q == PORT_A) && !rst;
  assign rvalid_b = rd_valid_q && (rd_tag_q == PORT_B) && !rst;
  assign rdata_a  = ram_dout;
  assign rdata_b  = ram_dout;

endmodule
